// File: rtl/t_1s_pkg.sv
// Shared constants and helpers for the periodic tick generator.
//   CLK_HZ_DEFAULT      : system clock frequency, shared with the UART and DDS blocks
//   cycles_per_interval : clock cycles in one tick interval (64-bit arithmetic)
//   interval_is_exact   : true when the interval is a whole number of cycles
package t_1s_pkg;

    localparam longint unsigned CLK_HZ_DEFAULT = 64'd50_000_000;

    function automatic longint unsigned cycles_per_interval(
        input longint unsigned clk_hz,
        input longint unsigned tick_ms
    );
        return (clk_hz * tick_ms) / 64'd1000;
    endfunction

    function automatic bit interval_is_exact(
        input longint unsigned clk_hz,
        input longint unsigned tick_ms
    );
        return ((clk_hz * tick_ms) % 64'd1000) == 64'd0;
    endfunction

endpackage

// File: rtl/t_1s.sv
// Periodic tick generator: a free-running counter that emits a strobe that is
// high for exactly one clk cycle every N = CLK_HZ * TICK_MS / 1000 cycles.
// Ports:
//   clk   : system clock, rising-edge active
//   rst_n : asynchronous active-low reset (clears counter and strobe)
//   s     : tick strobe, one cycle wide, first asserted after edge N
module t_1s
    import t_1s_pkg::*;
#(
    parameter longint unsigned CLK_HZ  = CLK_HZ_DEFAULT,
    parameter longint unsigned TICK_MS = 64'd1000
) (
    input  logic clk,
    input  logic rst_n,
    output logic s
);

    localparam longint unsigned N  = cycles_per_interval(CLK_HZ, TICK_MS);
    localparam int unsigned     CW = (N < 64'd2) ? 1 : $clog2(N);
    localparam logic [CW-1:0]   LAST = CW'(N - 64'd1);

    // Build-time guards: an unusable or fractional interval stops elaboration.
    if (N < 64'd2) begin : g_err_n_small
        $error("t_1s: N=%0d cycles per tick, must be at least 2", N);
    end
    if (N > 64'hFFFF_FFFF) begin : g_err_n_wide
        $error("t_1s: N=%0d cycles per tick does not fit in 32 bits", N);
    end
    if (!interval_is_exact(CLK_HZ, TICK_MS)) begin : g_err_fraction
        $error("t_1s: CLK_HZ*TICK_MS=%0d is not a whole number of kHz-ms",
               CLK_HZ * TICK_MS);
    end

    logic [CW-1:0] cnt_q, cnt_d;
    logic          s_q, s_d;

    always_comb begin
        cnt_d = '0;
        s_d   = 1'b0;
        if (cnt_q == LAST) begin
            s_d = 1'b1;
        end else if (cnt_q < LAST) begin
            cnt_d = cnt_q + CW'(1);
        end
        // Any out-of-range count (only possible after an upset) falls through
        // to reload 0 with no strobe, so a double pulse cannot occur.
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            s_q   <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            s_q   <= s_d;
        end
    end

    assign s = s_q;

`ifndef SYNTHESIS
    // A strobe is never followed by another strobe on the next cycle.
    a_single_cycle: assert property (@(posedge clk) disable iff (!rst_n) s_q |=> !s_q);
    // A strobe always coincides with the counter having just wrapped.
    a_strobe_at_wrap: assert property (@(posedge clk) disable iff (!rst_n) s_q |-> (cnt_q == '0));
`endif

endmodule

// File: tb/tb_t_1s.sv
module tb_t_1s;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst10_n, rst2_n, rstc_n;
    logic s10, s2, s50, sdef;

    // N = 10
    t_1s #(.CLK_HZ(64'd1000), .TICK_MS(64'd10)) u10 (.clk(clk), .rst_n(rst10_n), .s(s10));
    // N = 2 boundary
    t_1s #(.CLK_HZ(64'd2000), .TICK_MS(64'd1))  u2  (.clk(clk), .rst_n(rst2_n),  .s(s2));
    // N = 50, consumer/accumulator check over 2.1 intervals
    t_1s #(.CLK_HZ(64'd1000), .TICK_MS(64'd50)) u50 (.clk(clk), .rst_n(rstc_n),  .s(s50));
    // Default parameters (N = 50,000,000): must stay quiet over a short run
    t_1s udef (.clk(clk), .rst_n(rstc_n), .s(sdef));

    int checks = 0;
    int errors = 0;

    // Reference model state: rising edges seen since each reset release.
    int k10 = 0, k2 = 0, k50 = 0;
    int acc = 1000;
    int pulses10 = 0, last_pulse10 = -1, gap_bad = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Expected strobe after edge k of a counter with period n (k=0 means none yet).
    function automatic logic tick_exp(input logic rel, input int k, input int n);
        return rel && (k > 0) && ((k % n) == 0);
    endfunction

    // One clock edge, then compare every instance with the model.
    task automatic step();
        @(posedge clk);
        #2;
        if (rst10_n) k10++; else k10 = 0;
        if (rst2_n)  k2++;  else k2  = 0;
        if (rstc_n)  k50++; else k50 = 0;
        check("s10", 32'(s10), 32'(tick_exp(rst10_n, k10, 10)));
        check("s2",  32'(s2),  32'(tick_exp(rst2_n,  k2,  2)));
        check("s50", 32'(s50), 32'(tick_exp(rstc_n,  k50, 50)));
        check("sdef", 32'(sdef), 32'd0);
        if (!rst10_n) check("cnt10_rst", 32'(u10.cnt_q), 32'd0);
        if (rstc_n && k50 <= 105 && s50) acc += 100;
        if (s10) begin
            pulses10++;
            if (last_pulse10 >= 0 && (k10 - last_pulse10) != 10) gap_bad++;
            last_pulse10 = k10;
        end
    endtask

    // Assert u10 reset between edges, confirm s10 drops with no clock edge,
    // hold a random number of edges, then release.
    task automatic mid_reset(input string tag);
        int hold;
        #1;
        rst10_n = 1'b0;
        #1;
        check({tag, "_async"}, 32'(s10), 32'd0);
        hold = $urandom_range(1, 4);
        for (int i = 0; i < hold; i++) step();
        rst10_n = 1'b1;
        last_pulse10 = -1;
    endtask

    initial begin
        rst10_n = 1'b0;
        rst2_n  = 1'b0;
        rstc_n  = 1'b0;

        // Reset values held over 5 edges
        for (int i = 0; i < 5; i++) step();

        // Release all; 100 cycles of u10 gives 10 pulses spaced 10 apart
        rst10_n = 1'b1;
        rst2_n  = 1'b1;
        rstc_n  = 1'b1;
        pulses10 = 0;
        gap_bad  = 0;
        for (int i = 0; i < 100; i++) step();
        check("pulses_in_100", 32'(pulses10), 32'd10);
        check("pulse_spacing", 32'(gap_bad), 32'd0);

        // Finish the 2.1-interval consumer window for u50
        for (int i = 0; i < 10; i++) step();
        check("accumulator", 32'(acc), 32'd1200);

        // Reset at cycle 7 of a period
        for (int i = 0; i < 10 && (k10 % 10) != 7; i++) step();
        check("at_cycle7", 32'(k10 % 10), 32'd7);
        mid_reset("rst_cyc7");
        for (int i = 0; i < 25; i++) step();

        // Reset during the strobe-high cycle
        for (int i = 0; i < 10 && !s10; i++) step();
        check("strobe_high", 32'(s10), 32'd1);
        mid_reset("rst_strobe");
        for (int i = 0; i < 25; i++) step();

        // Randomised reset points and run lengths
        for (int r = 0; r < 8; r++) begin
            int run;
            run = $urandom_range(1, 40);
            for (int i = 0; i < run; i++) step();
            mid_reset("rst_rand");
        end
        for (int i = 0; i < 30; i++) step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
